// File: rtl/alu_if.sv
// Bus bundle for the 74181-style ALU slice: operation inputs and registered results.
interface alu_if;
    logic [3:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic       cn;
    logic       m;
    logic [3:0] f;
    logic       p;
    logic       g;
    logic       a_eq_b;
    logic       cn_4;

    // Requester side: drives the operation, observes the registered result.
    modport master (
        output s, a, b, cn, m,
        input  f, p, g, a_eq_b, cn_4
    );

    // ALU side: samples the operation, drives the registered result.
    modport slave (
        input  s, a, b, cn, m,
        output f, p, g, a_eq_b, cn_4
    );
endinterface

// File: rtl/alu_74181.sv
// Clocked 4-bit 74181 ALU slice (active-high data). Computes the 16 logic and
// 16 arithmetic functions of a and b plus the lookahead group outputs p/g,
// ripple carry-out cn_4 and the a_eq_b compare flag. One cycle of latency.
module alu_74181 (
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);

    // Per-bit propagate term selected by s[1:0]; a set a_i always propagates.
    function automatic logic [3:0] bit_prop(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] s);
        return a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    endfunction

    // Per-bit generate term selected by s[3:2]; always a subset of propagate.
    function automatic logic [3:0] bit_gen(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [3:0] s);
        return (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    endfunction

    logic [3:0] prop;
    logic [3:0] gen;
    logic [4:0] carry;

    logic [3:0] f_d;
    logic       p_d;
    logic       g_d;
    logic       cn_4_d;
    logic       a_eq_b_d;

    logic [3:0] f_q;
    logic       p_q;
    logic       g_q;
    logic       cn_4_q;
    logic       a_eq_b_q;

    // Combinational slice: P/G terms, ripple carry, result and group outputs.
    always_comb begin
        prop     = bit_prop(bus.a, bus.b, bus.s);
        gen      = bit_gen(bus.a, bus.b, bus.s);
        carry    = 5'b0;
        carry[0] = ~bus.cn;
        for (int i = 0; i < 4; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end

        // Logic mode ignores the carries entirely; arithmetic mode is P + G + c0.
        if (bus.m) begin
            f_d = ~(prop ^ gen);
        end else begin
            f_d = prop ^ gen ^ carry[3:0];
        end

        // Group outputs are mode-independent so cascading lookahead stays valid.
        p_d      = ~(&prop);
        g_d      = ~(gen[3]
                   | (prop[3] & gen[2])
                   | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0]));
        cn_4_d   = ~carry[4];
        a_eq_b_d = &f_d;
    end

    // Output register; reset forces the idle pattern and drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q      <= 4'h0;
            p_q      <= 1'b1;
            g_q      <= 1'b1;
            cn_4_q   <= 1'b1;
            a_eq_b_q <= 1'b0;
        end else begin
            f_q      <= f_d;
            p_q      <= p_d;
            g_q      <= g_d;
            cn_4_q   <= cn_4_d;
            a_eq_b_q <= a_eq_b_d;
        end
    end

    assign bus.f      = f_q;
    assign bus.p      = p_q;
    assign bus.g      = g_q;
    assign bus.cn_4   = cn_4_q;
    assign bus.a_eq_b = a_eq_b_q;

endmodule

// File: tb/tb_alu_74181.sv
// Self-checking bench for alu_74181: directed cases, exhaustive sweep and a
// randomized run with sporadic resets, all against a table-driven model.
module tb_alu_74181;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_if bus();

    alu_74181 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] RESET_OUT = {4'h0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model from the function tables. Arithmetic is described as the
    // sum of two operand words x + y + carry-in, where x is the propagate word
    // and y the generate word; the group outputs follow from that sum.
    // Returns {f, p, g, cn_4, a_eq_b}.
    function automatic logic [7:0] model(input logic [3:0] s, input logic [3:0] a,
                                         input logic [3:0] b, input logic cn,
                                         input logic m);
        logic [3:0] nb;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] lf;
        logic [3:0] f;
        int         sum;
        int         sum0;
        logic       p;
        logic       g;
        logic       c4n;
        nb = ~b;
        case (s)
            4'h0: begin x = a;       y = 4'h0;   end
            4'h1: begin x = a | b;   y = 4'h0;   end
            4'h2: begin x = a | nb;  y = 4'h0;   end
            4'h3: begin x = 4'hF;    y = 4'h0;   end
            4'h4: begin x = a;       y = a & nb; end
            4'h5: begin x = a | b;   y = a & nb; end
            4'h6: begin x = a | nb;  y = a & nb; end
            4'h7: begin x = 4'hF;    y = a & nb; end
            4'h8: begin x = a;       y = a & b;  end
            4'h9: begin x = a | b;   y = a & b;  end
            4'hA: begin x = a | nb;  y = a & b;  end
            4'hB: begin x = 4'hF;    y = a & b;  end
            4'hC: begin x = a;       y = a;      end
            4'hD: begin x = a | b;   y = a;      end
            4'hE: begin x = a | nb;  y = a;      end
            default: begin x = 4'hF; y = a;      end
        endcase
        case (s)
            4'h0: lf = ~a;
            4'h1: lf = ~(a | b);
            4'h2: lf = ~a & b;
            4'h3: lf = 4'h0;
            4'h4: lf = ~(a & b);
            4'h5: lf = ~b;
            4'h6: lf = a ^ b;
            4'h7: lf = a & ~b;
            4'h8: lf = ~a | b;
            4'h9: lf = ~(a ^ b);
            4'hA: lf = b;
            4'hB: lf = a & b;
            4'hC: lf = 4'hF;
            4'hD: lf = a | ~b;
            4'hE: lf = a | b;
            default: lf = a;
        endcase
        sum0 = int'(x) + int'(y);
        sum  = sum0 + (cn ? 0 : 1);
        f    = m ? lf : sum[3:0];
        c4n  = !(sum >= 16);
        g    = !(sum0 >= 16);
        p    = !(x == 4'hF);
        return {f, p, g, c4n, (f == 4'hF)};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.f, bus.p, bus.g, bus.cn_4, bus.a_eq_b};
    endfunction

    // Present one operation, let one edge pass, leave outputs settled for sampling.
    task automatic apply(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                         input logic cn, input logic m);
        bus.s  = s;
        bus.a  = a;
        bus.b  = b;
        bus.cn = cn;
        bus.m  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_check(input string tag, input logic [3:0] s, input logic [3:0] a,
                               input logic [3:0] b, input logic cn, input logic m);
        apply(s, a, b, cn, m);
        check(tag, observed(), model(s, a, b, cn, m));
    endtask

    initial begin
        logic [3:0] rs;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rcn;
        logic       rm;
        logic       rr;
        logic [7:0] exp;
        checks   = 0;
        failures = 0;

        // Reset held for two cycles with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            check("reset_hold", observed(), RESET_OUT);
        end
        rst = 1'b0;
        apply_check("post_reset_first", 4'h9, 4'h3, 4'h4, 1'b1, 1'b0);
        check("post_reset_f", 8'(bus.f), 8'h7);

        // Add.
        apply_check("add_7_8", 4'h9, 4'h7, 4'h8, 1'b1, 1'b0);
        check("add_7_8_f", 8'(bus.f), 8'hF);
        check("add_7_8_cn4", 8'(bus.cn_4), 8'h1);
        check("add_7_8_eq", 8'(bus.a_eq_b), 8'h1);
        apply_check("add_7_8_cin", 4'h9, 4'h7, 4'h8, 1'b0, 1'b0);
        check("add_cin_f", 8'(bus.f), 8'h0);
        check("add_cin_cn4", 8'(bus.cn_4), 8'h0);
        check("add_cin_eq", 8'(bus.a_eq_b), 8'h0);

        // Subtract / compare.
        apply_check("cmp_5_5", 4'h6, 4'h5, 4'h5, 1'b1, 1'b0);
        check("cmp_eq_f", 8'(bus.f), 8'hF);
        check("cmp_eq_flag", 8'(bus.a_eq_b), 8'h1);
        check("cmp_eq_cn4", 8'(bus.cn_4), 8'h1);
        apply_check("sub_5_3", 4'h6, 4'h5, 4'h3, 1'b0, 1'b0);
        check("sub_f", 8'(bus.f), 8'h2);
        check("sub_cn4", 8'(bus.cn_4), 8'h0);

        // Logic functions.
        apply_check("xor", 4'h6, 4'hC, 4'hA, 1'b1, 1'b1);
        check("xor_f", 8'(bus.f), 8'h6);
        apply_check("and", 4'hB, 4'hC, 4'hA, 1'b1, 1'b1);
        check("and_f", 8'(bus.f), 8'h8);
        apply_check("nota", 4'h0, 4'hC, 4'hA, 1'b1, 1'b1);
        check("nota_f", 8'(bus.f), 8'h3);
        apply_check("ones", 4'hC, 4'hC, 4'hA, 1'b0, 1'b1);
        check("ones_f", 8'(bus.f), 8'hF);
        check("ones_eq", 8'(bus.a_eq_b), 8'h1);

        // Group outputs.
        apply_check("grp_prop", 4'h9, 4'hF, 4'h0, 1'b1, 1'b0);
        check("grp_prop_p", 8'(bus.p), 8'h0);
        check("grp_prop_g", 8'(bus.g), 8'h1);
        for (int c = 0; c < 2; c++) begin
            apply_check("grp_gen", 4'h9, 4'h8, 4'h8, 1'(c), 1'b0);
            check("grp_gen_g", 8'(bus.g), 8'h0);
            check("grp_gen_cn4", 8'(bus.cn_4), 8'h0);
        end

        // Reset asserted mid-stream discards the pending result.
        rst = 1'b1;
        apply(4'h9, 4'hF, 4'hF, 1'b0, 1'b0);
        check("mid_reset", observed(), RESET_OUT);
        rst = 1'b0;
        apply_check("mid_reset_release", 4'hC, 4'h9, 4'h2, 1'b1, 1'b0);

        // Exhaustive sweep of {m, cn, s, a, b}, one operation per cycle.
        for (int i = 0; i < 16384; i++) begin
            apply_check("sweep", 4'(i >> 8), 4'(i >> 4), 4'(i), 1'(i >> 12), 1'(i >> 13));
        end

        // Randomized operations with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rs  = 4'($urandom);
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rcn = 1'($urandom);
            rm  = 1'($urandom);
            rr  = ($urandom_range(0, 31) == 0);
            rst = rr;
            exp = rr ? RESET_OUT : model(rs, ra, rb, rcn, rm);
            apply(rs, ra, rb, rcn, rm);
            check("random", observed(), exp);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
